// File: rtl/muldiv_scheduler_pkg.sv
// Shared encodings for the EX-stage multiply/divide scheduler.
package muldiv_scheduler_pkg;

    localparam int unsigned CNT_W = 4;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // True for ops that occupy the unit for a multi-cycle latency.
    function automatic logic is_long_op(mdu_op_e op);
        return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_scheduler_if.sv
// Issue/result bundle between the EX stage and the multiply/divide scheduler.
interface muldiv_scheduler_if;
    import muldiv_scheduler_pkg::*;

    logic        start;
    mdu_op_e     op;
    logic        cancel;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        id_uses_mdu;
    logic        busy;
    logic        stall_request;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, cancel, src_a, src_b, id_uses_mdu,
        input  busy, stall_request, hi, lo
    );

    modport slave (
        input  start, op, cancel, src_a, src_b, id_uses_mdu,
        output busy, stall_request, hi, lo
    );

endinterface

// File: rtl/muldiv_compute.sv
// Combinational 64-bit product and quotient/remainder for the MDU ops.
module muldiv_compute
    import muldiv_scheduler_pkg::*;
(
    input  mdu_op_e     op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic [63:0] product,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_by_zero
);

    logic        is_signed;
    logic        neg_a;
    logic        neg_b;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] div_b;
    logic [31:0] mag_q;
    logic [31:0] mag_r;

    always_comb begin
        is_signed = (op == MDU_MULT) || (op == MDU_DIV);
        neg_a     = is_signed & src_a[31];
        neg_b     = is_signed & src_b[31];

        // Low 64 bits of a sign/zero-extended product are exact for both flavours.
        ext_a   = {{32{neg_a}}, src_a};
        ext_b   = {{32{neg_b}}, src_b};
        product = ext_a * ext_b;

        // Divide magnitudes, then restore signs: quotient truncates toward zero,
        // remainder follows the dividend. Avoids signed-overflow corner cases.
        mag_a       = neg_a ? (~src_a + 32'd1) : src_a;
        mag_b       = neg_b ? (~src_b + 32'd1) : src_b;
        div_by_zero = (src_b == 32'd0);
        div_b       = div_by_zero ? 32'd1 : mag_b;
        mag_q       = mag_a / div_b;
        mag_r       = mag_a % div_b;
        quotient    = (neg_a ^ neg_b) ? (~mag_q + 32'd1) : mag_q;
        remainder   = neg_a ? (~mag_r + 32'd1) : mag_r;
    end

endmodule

// File: rtl/muldiv_scheduler.sv
// EX-stage MDU sequencer: fixed-latency busy window, HI/LO ownership and ID stall.
module muldiv_scheduler
    import muldiv_scheduler_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input logic              clk,
    input logic              reset,
    muldiv_scheduler_if.slave bus
);

    localparam logic [CNT_W-1:0] MultN = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DivN  = CNT_W'(DIV_CYCLES);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      pend_hi_q, pend_hi_d;
    logic [31:0]      pend_lo_q, pend_lo_d;
    logic             pend_dbz_q, pend_dbz_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;

    logic [63:0] product;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;
    logic        busy;
    logic        accept;

    muldiv_compute u_compute (
        .op          (bus.op),
        .src_a       (bus.src_a),
        .src_b       (bus.src_b),
        .product     (product),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    assign busy   = (state_q == ST_RUN);
    assign accept = bus.start & ~bus.cancel & ~busy;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pend_hi_d  = pend_hi_q;
        pend_lo_d  = pend_lo_q;
        pend_dbz_d = pend_dbz_q;
        hi_d       = hi_q;
        lo_d       = lo_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    unique case (bus.op)
                        MDU_MULT, MDU_MULTU: begin
                            pend_hi_d  = product[63:32];
                            pend_lo_d  = product[31:0];
                            pend_dbz_d = 1'b0;
                            cnt_d      = MultN;
                            state_d    = ST_RUN;
                        end
                        MDU_DIV, MDU_DIVU: begin
                            pend_hi_d  = remainder;
                            pend_lo_d  = quotient;
                            pend_dbz_d = div_by_zero;
                            cnt_d      = DivN;
                            state_d    = ST_RUN;
                        end
                        MDU_MTHI: hi_d = bus.src_a;
                        MDU_MTLO: lo_d = bus.src_a;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    if (!pend_dbz_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            pend_hi_q  <= '0;
            pend_lo_q  <= '0;
            pend_dbz_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pend_hi_q  <= pend_hi_d;
            pend_lo_q  <= pend_lo_d;
            pend_dbz_q <= pend_dbz_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    // The issue cycle itself must stall a dependent ID op before busy rises.
    assign bus.stall_request = bus.id_uses_mdu &
                               (busy | (bus.start & ~bus.cancel & is_long_op(bus.op)));
    assign bus.busy = busy;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_scheduler.sv
// Directed self-checking bench for muldiv_scheduler (default latencies plus a 1-cycle instance).
module tb_muldiv_scheduler;
    import muldiv_scheduler_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int          n_assert = 0;
    int          n_fail = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    always #5 clk = ~clk;

    muldiv_scheduler_if bus ();
    muldiv_scheduler_if bus1 ();

    muldiv_scheduler #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    muldiv_scheduler #(.MULT_CYCLES(1), .DIV_CYCLES(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_assert++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one long op, then check the busy window, frozen HI/LO and the commit.
    task automatic do_op(input string tag, input mdu_op_e o, input logic [31:0] a,
                         input logic [31:0] b, input int n, input logic [31:0] eh,
                         input logic [31:0] el, input logic hz);
        bus.op          = o;
        bus.src_a       = a;
        bus.src_b       = b;
        bus.start       = 1'b1;
        bus.id_uses_mdu = hz;
        #1;
        chk({tag, " issue stall"}, bus.stall_request, hz);
        step();
        bus.start = 1'b0;
        #1;
        for (int i = 0; i < n; i++) begin
            chk({tag, " busy"}, bus.busy, 1);
            chk({tag, " stall busy"}, bus.stall_request, hz);
            chk({tag, " hi held"}, bus.hi, m_hi);
            chk({tag, " lo held"}, bus.lo, m_lo);
            step();
        end
        m_hi = eh;
        m_lo = el;
        chk({tag, " busy end"}, bus.busy, 0);
        chk({tag, " stall end"}, bus.stall_request, 0);
        chk({tag, " hi"}, bus.hi, m_hi);
        chk({tag, " lo"}, bus.lo, m_lo);
        bus.id_uses_mdu = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset && bus.start && !bus.cancel && bus.busy) begin
            n_fail++;
            $display("FAIL protocol: start issued while busy");
        end
    end

    initial begin
        bus.start = 1'b0; bus.op = MDU_MULT; bus.cancel = 1'b0;
        bus.src_a = '0; bus.src_b = '0; bus.id_uses_mdu = 1'b0;
        bus1.start = 1'b0; bus1.op = MDU_MULT; bus1.cancel = 1'b0;
        bus1.src_a = '0; bus1.src_b = '0; bus1.id_uses_mdu = 1'b0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
        chk("reset busy", bus.busy, 0);
        chk("reset stall", bus.stall_request, 0);
        chk("reset hi", bus.hi, 0);
        chk("reset lo", bus.lo, 0);

        do_op("mult", MDU_MULT, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
        do_op("multu", MDU_MULTU, 32'hFFFF_FFFE, 32'd3, 5, 32'h0000_0002, 32'hFFFF_FFFA, 1'b0);
        do_op("div", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        do_op("div negb", MDU_DIV, 32'd7, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
        do_op("divu by0", MDU_DIVU, 32'd5, 32'd0, 10, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
        do_op("hazard div", MDU_DIV, 32'd100, 32'd7, 10, 32'h0000_0002, 32'h0000_000E, 1'b1);
        do_op("divu", MDU_DIVU, 32'hFFFF_FFF9, 32'd2, 10, 32'h0000_0001, 32'h7FFF_FFFC, 1'b1);

        // Cancelled issue: dropped, no stall, nothing changes.
        bus.op = MDU_MULT; bus.src_a = 32'd9; bus.src_b = 32'd9;
        bus.start = 1'b1; bus.cancel = 1'b1; bus.id_uses_mdu = 1'b1;
        #1;
        chk("cancel stall", bus.stall_request, 0);
        step();
        chk("cancel busy", bus.busy, 0);
        chk("cancel hi", bus.hi, m_hi);
        chk("cancel lo", bus.lo, m_lo);
        bus.start = 1'b0; bus.cancel = 1'b0;
        step();
        chk("cancel busy later", bus.busy, 0);

        // Moves write HI/LO at the accept edge and never stall.
        bus.op = MDU_MTLO; bus.src_a = 32'h1234_5678; bus.start = 1'b1;
        #1;
        chk("mtlo stall", bus.stall_request, 0);
        step();
        bus.start = 1'b0;
        m_lo = 32'h1234_5678;
        chk("mtlo busy", bus.busy, 0);
        chk("mtlo lo", bus.lo, m_lo);
        chk("mtlo hi", bus.hi, m_hi);
        bus.op = MDU_MTHI; bus.src_a = 32'hCAFE_F00D; bus.start = 1'b1;
        #1;
        chk("mthi stall", bus.stall_request, 0);
        step();
        bus.start = 1'b0; bus.id_uses_mdu = 1'b0;
        m_hi = 32'hCAFE_F00D;
        chk("mthi busy", bus.busy, 0);
        chk("mthi hi", bus.hi, m_hi);
        chk("mthi lo", bus.lo, m_lo);

        // Reset during busy cycle 3 aborts the op.
        bus.op = MDU_MULT; bus.src_a = 32'd3; bus.src_b = 32'd4; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("abort busy c1", bus.busy, 1);
        step();
        step();
        chk("abort busy c3", bus.busy, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        chk("abort busy", bus.busy, 0);
        chk("abort hi", bus.hi, m_hi);
        chk("abort lo", bus.lo, m_lo);
        repeat (6) step();
        chk("abort no commit busy", bus.busy, 0);
        chk("abort no commit hi", bus.hi, m_hi);
        chk("abort no commit lo", bus.lo, m_lo);

        // Single-cycle latency instance.
        bus1.op = MDU_MULT; bus1.src_a = 32'd7; bus1.src_b = 32'd6; bus1.start = 1'b1;
        step();
        bus1.start = 1'b0;
        #1;
        chk("n1 mult busy", bus1.busy, 1);
        chk("n1 mult lo held", bus1.lo, 0);
        step();
        chk("n1 mult busy end", bus1.busy, 0);
        chk("n1 mult hi", bus1.hi, 32'd0);
        chk("n1 mult lo", bus1.lo, 32'd42);
        bus1.op = MDU_DIV; bus1.src_a = 32'hFFFF_FFEC; bus1.src_b = 32'd3; bus1.start = 1'b1;
        step();
        bus1.start = 1'b0;
        #1;
        chk("n1 div busy", bus1.busy, 1);
        chk("n1 div lo held", bus1.lo, 32'd42);
        step();
        chk("n1 div busy end", bus1.busy, 0);
        chk("n1 div hi", bus1.hi, 32'hFFFF_FFFE);
        chk("n1 div lo", bus1.lo, 32'hFFFF_FFFA);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_scheduler.md
Name: muldiv_scheduler

Overview:
- Sequences the EX-stage multiply/divide unit and owns the architectural HI/LO registers.
- Accepts one mult/div/move-to op per issue, holds the unit busy for a fixed latency, then commits the result.
- Generates the stall request that holds the ID stage while an HI/LO consumer would observe a stale value.
- Honours cancellation from exceptions/eret, so a squashed instruction never alters HI/LO.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (range 1..15)
DIV_CYCLES, 10, busy cycles for div/divu (range 1..15)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  EX-stage instruction is an MDU op this cycle
op  input  3  MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO (package encodings)
cancel  input  1  EX instruction is squashed (exception/eret flush); suppresses start
src_a  input  32  rs operand (forwarded)
src_b  input  32  rt operand (forwarded)
id_uses_mdu  input  1  ID-stage instruction is mult/div/mfhi/mflo/mthi/mtlo
busy  output  1  latency counter running
stall_request  output  1  hold PC/IF-ID, bubble ID-EX
hi  output  32  architectural HI
lo  output  32  architectural LO

Behaviour:
- accept = start & ~cancel & ~busy; sampled at the rising edge.
- FSM states: IDLE, RUN.
- IDLE:
  - accept with mult/multu: latch 64-bit product of src_a*src_b (signed/unsigned per op) into pend_hi/pend_lo; counter = MULT_CYCLES; go RUN.
  - accept with div/divu: pend_lo = quotient, pend_hi = remainder (signed: quotient truncates toward zero, remainder takes dividend's sign); counter = DIV_CYCLES; go RUN.
  - div/divu with src_b == 0: still RUN for DIV_CYCLES; commit is suppressed and HI/LO are unchanged.
  - accept with mthi/mtlo: hi (resp. lo) = src_a at that same edge; stay IDLE; busy stays 0.
- RUN:
  - counter decrements each edge.
  - At the edge where counter goes 1->0: hi/lo = pend_hi/pend_lo (unless div-by-zero); go IDLE.
  - busy = (state == RUN). Op accepted at edge T0 gives busy high during cycles T0+1 .. T0+N; new hi/lo visible from T0+N.
- start while busy: ignored, no state change. Upstream guarantees this cannot happen via stall_request; the bench flags it as a protocol error.
- cancel: while busy it has no effect, since an accepted op is already committed in program order. With start in the same cycle, the op is dropped entirely.
- stall_request = id_uses_mdu & (busy | (start & ~cancel & op is mult/multu/div/divu)). Combinational; covers the issue cycle. mthi/mtlo never cause a stall.
- Reset has priority over everything:
  - hi = lo = 0, pend = 0, counter = 0, state IDLE, busy = 0, stall_request = 0 (given id_uses_mdu = 0).
  - Reset mid-RUN aborts the op; no commit.
- N = 1 boundary: busy for exactly one cycle; commit on the next edge.

Decomposition:
- Shared package holds:
  - op encodings MDU_MULT=0, MDU_MULTU=1, MDU_DIV=2, MDU_DIVU=3, MDU_MTHI=4, MDU_MTLO=5;
  - state encodings ST_IDLE/ST_RUN;
  - 4-bit counter width constant.
- One sub-module, muldiv_compute: purely combinational 64-bit product and quotient/remainder from op, src_a, src_b, plus a div_by_zero flag.
- Scheduler FSM, counter, pending registers and HI/LO stay in muldiv_scheduler.

Test Plan:
- mult: src_a=0xFFFFFFFE (-2), src_b=3, start at T0 -> busy during T0+1..T0+5; hi=0xFFFFFFFF, lo=0xFFFFFFFA from T0+5; unchanged before.
- multu: same operands -> hi=0x00000002, lo=0xFFFFFFFA after 5 cycles.
- div: src_a=-7, src_b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1) after 10 cycles.
- divu by zero: src_a=5, src_b=0 -> busy 10 cycles; hi/lo keep their prior values.
- Hazard: div accepted, then id_uses_mdu=1 (mflo) every cycle -> stall_request=1 in the issue cycle and all 10 busy cycles; drops to 0 the cycle busy falls.
- start with cancel=1 on mult -> busy stays 0, no stall, hi/lo unchanged.
- mtlo src_a=0x12345678 -> lo updated next edge with busy=0.
- reset asserted at busy cycle 3 -> next cycle busy=0, hi=lo=0, no later commit.
